axi_write_burst_scheduler: RTL and testbench

- Upstream request generator for the AXI write state core. Once per frame it walks a 2-D frame buffer (lines × beats per line, with a byte stride between lines).
- Splits each line into AXI INCR bursts of at most BURST_MAX beats that never cross a 4 KB boundary.
- Issues each burst as a write_req / req_len / req_addr transaction to the core only when the data FIFO already holds the full burst.
- Reports frame completion and sync misses to the VDMA control logic.

---
 rtl/axi_write_burst_scheduler_if.sv | 28 ++
 rtl/axi_write_burst_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_axi_write_burst_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_burst_scheduler_if.sv
// Request handshake between the frame burst scheduler (master) and the
// AXI write core (slave): one burst request outstanding at a time.
interface axi_write_burst_scheduler_if #(
  parameter int ASIZE = 32,
  parameter int LSIZE = 10
);
  logic             write_req;
  logic [LSIZE-1:0] req_len;
  logic [ASIZE-1:0] req_addr;
  logic             req_resp;
  logic             req_done;

  modport master (
    output write_req,
    output req_len,
    output req_addr,
    input  req_resp,
    input  req_done
  );

  modport slave (
    input  write_req,
    input  req_len,
    input  req_addr,
    output req_resp,
    output req_done
  );
endinterface

// File: rtl/axi_write_burst_scheduler.sv
// Walks a 2-D frame buffer once per fsync and issues INCR burst requests
// that are capped at BURST_MAX beats, never cross a 4 KB boundary and are
// only raised once the data FIFO already holds the whole burst.
module axi_write_burst_scheduler #(
  parameter int ASIZE      = 32,
  parameter int LSIZE      = 10,
  parameter int CNT_W      = 16,
  parameter int BURST_MAX  = 256,
  parameter int BEAT_BYTES = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  input  logic                 fsync,
  input  logic [ASIZE-1:0]     frame_base,
  input  logic [CNT_W-1:0]     line_beats,
  input  logic [CNT_W-1:0]     line_num,
  input  logic [ASIZE-1:0]     line_stride,
  input  logic [CNT_W-1:0]     fifo_count,
  axi_write_burst_scheduler_if.master req_if,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 sync_miss
);

  localparam int BSHIFT = $clog2(BEAT_BYTES);

  localparam logic [ASIZE-1:0] ZERO_A     = {ASIZE{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [LSIZE-1:0] ZERO_L     = {LSIZE{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] BMAX_C     = CNT_W'(BURST_MAX);
  // Clears the sub-beat address bits so every address is beat aligned.
  localparam logic [ASIZE-1:0] ALIGN_MASK = ~(ASIZE'(BEAT_BYTES - 1));

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_REQ       = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ADV       = 3'd5,
    S_FDONE     = 3'd6
  } state_t;

  state_t           r_state;
  logic [ASIZE-1:0] r_line_addr;
  logic [ASIZE-1:0] r_cur_addr;
  logic [ASIZE-1:0] r_stride;
  logic [CNT_W-1:0] r_line_beats;
  logic [CNT_W-1:0] r_line_num;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] r_line_cnt;
  logic [LSIZE-1:0] r_req_len;
  logic [ASIZE-1:0] r_req_addr;
  logic             r_write_req;
  logic             r_frame_busy;
  logic             r_frame_done;
  logic             r_sync_miss;

  logic [ASIZE-1:0] w_base_aligned;
  logic [ASIZE-1:0] w_stride_aligned;
  logic [12:0]      w_room_beats;
  logic [CNT_W-1:0] w_min_rr;
  logic [LSIZE-1:0] w_blen;
  logic [CNT_W-1:0] w_len_ext;
  logic [ASIZE-1:0] w_adv_addr;
  logic [CNT_W-1:0] w_adv_remain;
  logic [CNT_W-1:0] w_next_line_cnt;
  logic [ASIZE-1:0] w_next_line_addr;
  logic             w_fifo_ready;
  logic             w_empty_frame;

  assign w_base_aligned   = frame_base & ALIGN_MASK;
  assign w_stride_aligned = line_stride & ALIGN_MASK;

  // Beats left before the next 4 KB page; at most 4096 / BEAT_BYTES.
  assign w_room_beats = (13'h1000 - {1'b0, r_cur_addr[11:0]}) >> BSHIFT;
  assign w_min_rr     = (r_remain < {{(CNT_W-13){1'b0}}, w_room_beats})
                        ? r_remain : {{(CNT_W-13){1'b0}}, w_room_beats};
  assign w_blen       = LSIZE'((w_min_rr < BMAX_C) ? w_min_rr : BMAX_C);

  assign w_len_ext        = {{(CNT_W-LSIZE){1'b0}}, r_req_len};
  assign w_adv_addr       = r_cur_addr + ({{(ASIZE-LSIZE){1'b0}}, r_req_len} << BSHIFT);
  assign w_adv_remain     = r_remain - w_len_ext;
  assign w_next_line_cnt  = r_line_cnt + ONE_C;
  assign w_next_line_addr = r_line_addr + r_stride;
  assign w_fifo_ready     = (fifo_count >= w_len_ext);
  assign w_empty_frame    = (line_beats == ZERO_C) || (line_num == ZERO_C);

  assign req_if.write_req = r_write_req;
  assign req_if.req_len   = r_req_len;
  assign req_if.req_addr  = r_req_addr;
  assign frame_busy       = r_frame_busy;
  assign frame_done       = r_frame_done;
  assign sync_miss        = r_sync_miss;

  // Frame walker FSM: every output is a register updated alongside the state.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= S_IDLE;
      r_line_addr  <= ZERO_A;
      r_cur_addr   <= ZERO_A;
      r_stride     <= ZERO_A;
      r_line_beats <= ZERO_C;
      r_line_num   <= ZERO_C;
      r_remain     <= ZERO_C;
      r_line_cnt   <= ZERO_C;
      r_req_len    <= ZERO_L;
      r_req_addr   <= ZERO_A;
      r_write_req  <= 1'b0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_miss  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // An fsync seen outside IDLE (FDONE included) is only reported.
      r_sync_miss  <= fsync && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (fsync) begin
            r_line_addr  <= w_base_aligned;
            r_cur_addr   <= w_base_aligned;
            r_stride     <= w_stride_aligned;
            r_line_beats <= line_beats;
            r_line_num   <= line_num;
            r_remain     <= line_beats;
            r_line_cnt   <= ZERO_C;
            if (w_empty_frame) begin
              r_frame_busy <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_FDONE;
            end else begin
              r_frame_busy <= 1'b1;
              r_state      <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_req_len  <= w_blen;
          r_req_addr <= r_cur_addr;
          r_state    <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (w_fifo_ready) begin
            r_write_req <= 1'b1;
            r_state     <= S_REQ;
          end else begin
            r_state <= S_WAIT_DATA;
          end
        end
        S_REQ: begin
          if (req_if.req_resp) begin
            r_write_req <= 1'b0;
            r_state     <= S_WAIT_DONE;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT_DONE: begin
          if (req_if.req_done) begin
            r_state <= S_ADV;
          end else begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_ADV: begin
          if (w_adv_remain == ZERO_C) begin
            // Line finished: restart at the next line start.
            r_line_cnt  <= w_next_line_cnt;
            r_line_addr <= w_next_line_addr;
            r_cur_addr  <= w_next_line_addr;
            r_remain    <= r_line_beats;
            if (w_next_line_cnt == r_line_num) begin
              r_frame_busy <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_FDONE;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_cur_addr <= w_adv_addr;
            r_remain   <= w_adv_remain;
            r_state    <= S_CALC;
          end
        end
        S_FDONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_write_req  <= 1'b0;
          r_frame_busy <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_burst_scheduler.sv
// Bench for axi_write_burst_scheduler: a burst-list model of each frame plus
// cycle-timing expectations derived from the latency rules, compared with the
// DUT every cycle while a randomized core model answers the requests.
`timescale 1ns/1ps
module tb_axi_write_burst_scheduler;
  localparam int ASIZE = 32;
  localparam int LSIZE = 10;
  localparam int CNT_W = 16;

  logic             axi_aclk = 1'b0;
  logic             axi_reset = 1'b1;
  logic             fsync = 1'b0;
  logic [ASIZE-1:0] frame_base = '0;
  logic [CNT_W-1:0] line_beats = '0;
  logic [CNT_W-1:0] line_num = '0;
  logic [ASIZE-1:0] line_stride = '0;
  logic [CNT_W-1:0] fifo_count = '0;
  logic             frame_busy;
  logic             frame_done;
  logic             sync_miss;

  axi_write_burst_scheduler_if #(.ASIZE(ASIZE), .LSIZE(LSIZE)) req_if ();

  axi_write_burst_scheduler #(
    .ASIZE(ASIZE), .LSIZE(LSIZE), .CNT_W(CNT_W), .BURST_MAX(256), .BEAT_BYTES(32)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_reset  (axi_reset),
    .fsync      (fsync),
    .frame_base (frame_base),
    .line_beats (line_beats),
    .line_num   (line_num),
    .line_stride(line_stride),
    .fifo_count (fifo_count),
    .req_if     (req_if),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .sync_miss  (sync_miss)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] q_addr[$];
  int          q_len[$];
  int frame_start, first_rise, hi_cycles, rises;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
    cyc++;
  endtask

  // Expected burst list of a frame, straight from the splitting rules.
  task automatic build_expected(input logic [31:0] base, input logic [15:0] beats,
                                input logic [15:0] lines, input logic [31:0] stride);
    logic [31:0] la, st, a;
    int rem, blen, room;
    q_addr.delete();
    q_len.delete();
    if (beats == 16'd0 || lines == 16'd0) return;
    la = base & ~32'h1F;
    st = stride & ~32'h1F;
    for (int l = 0; l < int'(lines); l++) begin
      a = la + st * 32'(l);
      rem = int'(beats);
      while (rem > 0) begin
        room = (4096 - int'(a[11:0])) / 32;
        blen = rem;
        if (room < blen) blen = room;
        if (256 < blen) blen = 256;
        q_addr.push_back(a);
        q_len.push_back(blen);
        a = a + 32'(blen * 32);
        rem = rem - blen;
      end
    end
  endtask

  task automatic do_reset();
    #2;
    axi_reset = 1'b1;
    tick();
    tick();
    axi_reset = 1'b0;
  endtask

  // Runs one frame: drives fsync now, plays the core, checks every cycle.
  task automatic run_frame(input logic [31:0] base, input logic [15:0] beats,
                           input logic [15:0] lines, input logic [31:0] stride,
                           input int fifo_mode, input int resp_min, input int resp_max,
                           input int done_max, input int stray_pct, input bit abort);
    int k, eval_c, fdone_c, miss_c, resp_cnt, done_cnt, t, n_exp;
    bit exp_wr, exp_wr_nxt, exp_wr_prev, wait_done, finished, degen, nonidle;
    build_expected(base, beats, lines, stride);
    n_exp = q_addr.size();
    degen = (beats == 16'd0) || (lines == 16'd0);
    k = cyc;
    frame_start = k;
    first_rise = -1;
    hi_cycles = 0;
    rises = 0;
    frame_base = base;
    line_beats = beats;
    line_num = lines;
    line_stride = stride;
    fsync = 1'b1;
    // fsync cycle k: CALC in k+1, WAIT_DATA from k+2.
    eval_c = degen ? -1 : k + 2;
    fdone_c = degen ? k + 1 : -1;
    miss_c = -1;
    resp_cnt = 0;
    done_cnt = 0;
    exp_wr_nxt = 1'b0;
    exp_wr_prev = 1'b0;
    wait_done = 1'b0;
    finished = 1'b0;
    while (!finished && cyc < k + 4000) begin
      tick();
      t = cyc;
      fsync = 1'b0;
      req_if.req_resp = 1'b0;
      req_if.req_done = 1'b0;
      if (t == k + 1) begin
        frame_base = $urandom;
        line_beats = 16'($urandom);
        line_num = 16'($urandom);
        line_stride = $urandom;
      end
      exp_wr = exp_wr_nxt;
      chk("write_req", req_if.write_req, exp_wr);
      if (exp_wr) begin
        chk("req_addr", req_if.req_addr, q_addr[0]);
        chk("req_len", req_if.req_len, q_len[0]);
        hi_cycles++;
        if (!exp_wr_prev) begin
          rises++;
          if (first_rise < 0) first_rise = t;
        end
      end
      exp_wr_prev = exp_wr;
      chk("frame_busy", frame_busy, !degen && t >= k + 1 && (fdone_c < 0 || t < fdone_c));
      chk("frame_done", frame_done, t == fdone_c);
      chk("sync_miss", sync_miss, t == miss_c);
      if (fdone_c >= 0 && t == fdone_c + 2) begin
        finished = 1'b1;
      end else begin
        case (fifo_mode)
          1: fifo_count = 16'($urandom_range(300, 0));
          2: fifo_count = (t < k + 8) ? 16'd10 : 16'd16;
          default: fifo_count = 16'd1000;
        endcase
        exp_wr_nxt = exp_wr;
        if (exp_wr) begin
          if (resp_cnt == 0) begin
            req_if.req_resp = 1'b1;
            exp_wr_nxt = 1'b0;
            wait_done = 1'b1;
            done_cnt = int'($urandom_range(done_max, 1)) - 1;
          end else begin
            resp_cnt--;
          end
        end else if (wait_done) begin
          if (abort) begin
            #2;
            axi_reset = 1'b1;
            #1;
            chk("rst_write_req", req_if.write_req, 1'b0);
            chk("rst_req_len", req_if.req_len, 10'd0);
            chk("rst_req_addr", req_if.req_addr, 32'd0);
            chk("rst_frame_busy", frame_busy, 1'b0);
            chk("rst_frame_done", frame_done, 1'b0);
            chk("rst_sync_miss", sync_miss, 1'b0);
            tick();
            tick();
            axi_reset = 1'b0;
            return;
          end
          if (done_cnt == 0) begin
            req_if.req_done = 1'b1;
            wait_done = 1'b0;
            void'(q_addr.pop_front());
            void'(q_len.pop_front());
            // req_done cycle t: ADV t+1, then FDONE or CALC t+2, WAIT_DATA t+3.
            if (q_addr.size() == 0) fdone_c = t + 2;
            else eval_c = t + 3;
          end else begin
            done_cnt--;
          end
        end else if (eval_c >= 0 && t >= eval_c) begin
          if (int'(fifo_count) >= q_len[0]) begin
            exp_wr_nxt = 1'b1;
            eval_c = -1;
            resp_cnt = int'($urandom_range(resp_max, resp_min));
          end
        end
        nonidle = (t >= k + 1) && (fdone_c < 0 || t <= fdone_c);
        if (nonidle && int'($urandom_range(99, 0)) < stray_pct) begin
          fsync = 1'b1;
          miss_c = t + 1;
        end
      end
    end
    chk("frame_finished", finished, 1'b1);
    chk("burst_count", rises, n_exp);
    if (!finished) do_reset();
  endtask

  initial begin
    logic [31:0] rb;
    req_if.req_resp = 1'b0;
    req_if.req_done = 1'b0;
    fifo_count = 16'd1000;
    // Reset state
    tick();
    tick();
    chk("reset_write_req", req_if.write_req, 1'b0);
    chk("reset_req_len", req_if.req_len, 10'd0);
    chk("reset_req_addr", req_if.req_addr, 32'd0);
    chk("reset_frame_busy", frame_busy, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_sync_miss", sync_miss, 1'b0);
    axi_reset = 1'b0;
    tick();

    // Two lines of 64 beats, immediate core response.
    build_expected(32'h1000_0000, 16'd64, 16'd2, 32'h1000);
    chk("t1_model_n", q_addr.size(), 2);
    chk("t1_model_a0", q_addr[0], 32'h1000_0000);
    chk("t1_model_l0", q_len[0], 64);
    chk("t1_model_a1", q_addr[1], 32'h1000_1000);
    chk("t1_model_l1", q_len[1], 64);
    run_frame(32'h1000_0000, 16'd64, 16'd2, 32'h1000, 0, 0, 0, 1, 0, 1'b0);
    // fsync cycle, CALC, WAIT_DATA, then write_req.
    chk("t1_fsync_latency", first_rise - frame_start, 3);
    tick();

    // 4 KB page split of a 300-beat line starting 256 bytes below a page.
    build_expected(32'h0000_0F00, 16'd300, 16'd1, 32'h0);
    chk("t2_model_n", q_addr.size(), 4);
    chk("t2_model_a0", q_addr[0], 32'h0000_0F00);
    chk("t2_model_l0", q_len[0], 8);
    chk("t2_model_a1", q_addr[1], 32'h0000_1000);
    chk("t2_model_l1", q_len[1], 128);
    chk("t2_model_a3", q_addr[3], 32'h0000_3000);
    chk("t2_model_l3", q_len[3], 36);
    run_frame(32'h0000_0F00, 16'd300, 16'd1, 32'h0, 0, 0, 3, 3, 0, 1'b0);
    tick();

    // FIFO holds 10 of 16 beats until frame cycle 8.
    run_frame(32'h0000_0000, 16'd16, 16'd1, 32'h0, 2, 0, 0, 2, 0, 1'b0);
    chk("t3_fifo_gate_latency", first_rise - frame_start, 9);
    tick();

    // Core accepts 20 cycles late: request held for 21 cycles.
    run_frame(32'h0000_2000, 16'd32, 16'd1, 32'h0, 0, 20, 20, 2, 0, 1'b0);
    chk("t4_hold_cycles", hi_cycles, 21);
    tick();

    // Stray fsyncs during a frame, then empty frames.
    run_frame(32'h1000_0000, 16'd64, 16'd2, 32'h1000, 0, 0, 2, 2, 30, 1'b0);
    run_frame(32'h0000_0100, 16'd10, 16'd0, 32'h40, 0, 0, 0, 1, 0, 1'b0);
    run_frame(32'h0000_0100, 16'd0, 16'd3, 32'h40, 0, 0, 0, 1, 0, 1'b0);
    tick();

    // Reset while waiting for req_done, then silence until a new fsync.
    run_frame(32'h0400_0000, 16'd200, 16'd2, 32'h2000, 0, 1, 3, 3, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      fifo_count = 16'd1000;
      tick();
      chk("post_reset_write_req", req_if.write_req, 1'b0);
      chk("post_reset_busy", frame_busy, 1'b0);
    end
    run_frame(32'h0400_0000, 16'd200, 16'd2, 32'h2000, 0, 0, 3, 3, 0, 1'b0);
    chk("restart_first_addr_model", (first_rise >= 0), 1'b1);
    tick();

    // Randomized frames.
    for (int n = 0; n < 25; n++) begin
      rb = $urandom;
      run_frame(rb, 16'($urandom_range(300, 1)), 16'($urandom_range(3, 1)), $urandom,
                int'($urandom_range(1, 0)), 0, int'($urandom_range(5, 0)),
                int'($urandom_range(5, 1)), 5, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
